// File: rtl/data_mem_bridge.sv
// Core load/store to 32-bit word-bus bridge: lane steering, load formatting and response timeout.
// Optional build macro MISALIGN_CHECK_EN rejects misaligned H/HU/W accesses without a bus request.
module data_mem_bridge #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [2:0]        core_size,
  output logic [31:0]       core_rdata,
  output logic              core_stall,
  output logic              misalign_err,
  output logic              bus_err,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_rsp_valid,
  input  logic [31:0]       bus_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} kind_t;

  // Unsupported size codes fall through to a full-word access.
  function automatic kind_t f_kind(input logic [2:0] size);
    case (size)
      3'b000, 3'b100: f_kind = SZ_B;
      3'b001, 3'b101: f_kind = SZ_H;
      default:        f_kind = SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] f_wstrb(input logic we, input kind_t kind, input logic [1:0] lo);
    f_wstrb = 4'b0000;
    if (we) begin
      case (kind)
        SZ_B:    f_wstrb = 4'b0001 << lo;
        SZ_H:    f_wstrb = lo[1] ? 4'b1100 : 4'b0011;
        default: f_wstrb = 4'b1111;
      endcase
    end
  endfunction

  function automatic logic [31:0] f_wdata(input kind_t kind, input logic [31:0] wdata);
    case (kind)
      SZ_B:    f_wdata = {4{wdata[7:0]}};
      SZ_H:    f_wdata = {2{wdata[15:0]}};
      default: f_wdata = wdata;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input kind_t kind, input logic uns, input logic [1:0] lo,
                                         input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (kind)
      SZ_B:    f_load = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_H:    f_load = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: f_load = word;
    endcase
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  kind_t            r_kind;
  logic             r_uns;
  logic [1:0]       r_lo;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [31:0]      r_bus_wdata;
  logic [3:0]       r_bus_wstrb;
  logic             r_bus_req_valid;
  logic [31:0]      r_rdata;
  logic             r_misalign_err;
  logic             r_bus_err;

  kind_t       w_kind;
  logic        w_misalign;
  logic [31:0] w_load;

  assign w_kind = f_kind(core_size);
  assign w_load = f_load(r_kind, r_uns, r_lo, bus_rdata);

`ifdef MISALIGN_CHECK_EN
  assign w_misalign = ((w_kind == SZ_H) && core_addr[0]) ||
                      ((w_kind == SZ_W) && (core_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_we            <= 1'b0;
      r_kind          <= SZ_B;
      r_uns           <= 1'b0;
      r_lo            <= 2'b00;
      r_bus_addr      <= '0;
      r_bus_wdata     <= '0;
      r_bus_wstrb     <= 4'b0000;
      r_bus_req_valid <= 1'b0;
      r_rdata         <= '0;
      r_misalign_err  <= 1'b0;
      r_bus_err       <= 1'b0;
    end else begin
      r_misalign_err <= 1'b0;
      r_bus_err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (core_req) begin
            r_we        <= core_we;
            r_kind      <= w_kind;
            r_uns       <= core_size[2];
            r_lo        <= core_addr[1:0];
            r_bus_addr  <= {core_addr[ADDR_W-1:2], 2'b00};
            r_bus_wdata <= f_wdata(w_kind, core_wdata);
            if (w_misalign) begin
              r_bus_wstrb    <= 4'b0000;
              r_misalign_err <= 1'b1;
              if (!core_we) r_rdata <= '0;
              r_state        <= DONE;
            end else begin
              r_bus_wstrb     <= f_wstrb(core_we, w_kind, core_addr[1:0]);
              r_bus_req_valid <= 1'b1;
              r_state         <= REQ;
            end
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            r_bus_req_valid <= 1'b0;
            r_cnt           <= '0;
            if (bus_rsp_valid) begin
              if (!r_we) r_rdata <= w_load;
              r_state <= DONE;
            end else begin
              r_state <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          // A response in the final allowed cycle still wins over the abort.
          if (bus_rsp_valid) begin
            r_cnt <= '0;
            if (!r_we) r_rdata <= w_load;
            r_state <= DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_cnt     <= '0;
            r_bus_err <= 1'b1;
            r_rdata   <= '0;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign core_stall = !rst && (((r_state == IDLE) && core_req) ||
                               (r_state == REQ) || (r_state == WAIT_RSP));

  assign core_rdata    = r_rdata;
  assign misalign_err  = r_misalign_err;
  assign bus_err       = r_bus_err;
  assign bus_req_valid = r_bus_req_valid;
  assign bus_addr      = r_bus_addr;
  assign bus_we        = r_we;
  assign bus_wdata     = r_bus_wdata;
  assign bus_wstrb     = r_bus_wstrb;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Randomized bench for data_mem_bridge with a transaction-level model and per-cycle compare.
// Misalignment expectations follow MISALIGN_CHECK_EN when the bench is built with it.
module tb_data_mem_bridge;
  localparam int T     = 8;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic [2:0]  core_size;
  logic [31:0] core_rdata;
  logic        core_stall, misalign_err, bus_err, bus_req_valid, bus_req_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_we, bus_rsp_valid;
  logic [3:0]  bus_wstrb;

  data_mem_bridge #(.ADDR_W(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_size(core_size), .core_rdata(core_rdata),
    .core_stall(core_stall), .misalign_err(misalign_err), .bus_err(bus_err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
    .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // expectations for the current cycle, written by the driver
  logic        chk_en = 1'b0, chk_bus = 1'b0;
  logic        e_stall, e_breq, e_berr, e_merr, e_bwe;
  logic [31:0] e_rdata, e_baddr, e_bwdata, e_wmask;
  logic [3:0]  e_bstrb;
  logic [31:0] m_rdata;
  logic        lit_en = 1'b0;
  string       lit_name;
  logic [31:0] lit_act, lit_exp;

  int n_checks = 0;
  int n_fail   = 0;

  int          obs_stall, obs_valid, obs_berr, obs_merr;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_strb;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("core_stall", 32'(core_stall), 32'(e_stall));
      check("bus_req_valid", 32'(bus_req_valid), 32'(e_breq));
      check("bus_err", 32'(bus_err), 32'(e_berr));
      check("misalign_err", 32'(misalign_err), 32'(e_merr));
      check("core_rdata", core_rdata, e_rdata);
      if (chk_bus) begin
        check("bus_addr", bus_addr, e_baddr);
        check("bus_we", 32'(bus_we), 32'(e_bwe));
        check("bus_wstrb", 32'(bus_wstrb), 32'(e_bstrb));
        if (e_wmask != 32'h0) check("bus_wdata", bus_wdata & e_wmask, e_bwdata & e_wmask);
      end
    end
    if (lit_en) check(lit_name, lit_act, lit_exp);
  end

  // 0 = byte, 1 = half, 2 = word
  function automatic int kind_of(input logic [2:0] s);
    case (s)
      3'b000, 3'b100: return 0;
      3'b001, 3'b101: return 1;
      default:        return 2;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] size, input logic [1:0] lo,
                                             input logic [31:0] word);
    logic [31:0] v;
    bit          uns;
    uns = (size == 3'b100) || (size == 3'b101);
    case (kind_of(size))
      0: begin
        v = (word >> (8 * int'(lo))) & 32'hFF;
        if (!uns && v >= 32'h80) v = v - 32'h100;
      end
      1: begin
        v = (word >> (16 * int'(lo[1]))) & 32'hFFFF;
        if (!uns && v >= 32'h8000) v = v - 32'h10000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
    if (core_stall) obs_stall++;
    if (bus_req_valid) obs_valid++;
    if (bus_req_valid && bus_req_ready) begin
      obs_addr  = bus_addr;
      obs_strb  = bus_wstrb;
      obs_wdata = bus_wdata;
    end
    if (bus_err) obs_berr++;
    if (misalign_err) obs_merr++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    core_req = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    e_stall = 1'b0; e_breq = 1'b0; e_berr = 1'b0; e_merr = 1'b0;
    e_rdata = m_rdata; chk_bus = 1'b0;
  endtask

  task automatic lit_check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    set_idle();
    lit_name = nm; lit_act = act; lit_exp = exp; lit_en = 1'b1;
    step();
    lit_en = 1'b0;
  endtask

  // dr: REQ cycles before ready; ds: cycles after handshake until rsp (0 = same cycle, NEVER = none)
  task automatic do_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int dr, input int ds, input logic gap);
    int          k;
    logic [1:0]  lo;
    logic [3:0]  strb;
    logic [31:0] ew, mask;
    bit          misal, tmo, on;
    k = kind_of(size);
    lo = addr[1:0];
    misal = 1'b0;
`ifdef MISALIGN_CHECK_EN
    misal = (k == 1 && lo[0]) || (k == 2 && lo != 2'b00);
`endif
    strb = 4'b0; ew = 32'h0; mask = 32'h0;
    for (int i = 0; i < 4; i++) begin
      case (k)
        0:       on = (i == int'(lo));
        1:       on = ((i / 2) == int'(lo[1]));
        default: on = 1'b1;
      endcase
      if (we && on) begin
        strb[i] = 1'b1;
        mask[8*i +: 8] = 8'hFF;
        case (k)
          0:       ew[8*i +: 8] = wdata[7:0];
          1:       ew[8*i +: 8] = wdata[8*(i%2) +: 8];
          default: ew[8*i +: 8] = wdata[8*i +: 8];
        endcase
      end
    end
    obs_stall = 0; obs_valid = 0; obs_berr = 0; obs_merr = 0;
    obs_addr = 32'h0; obs_strb = 4'h0; obs_wdata = 32'h0;

    core_req = 1'b1; core_we = we; core_size = size; core_addr = addr; core_wdata = wdata;
    bus_rdata = rdata; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    e_stall = 1'b1; e_breq = 1'b0; e_berr = 1'b0; e_merr = 1'b0; e_rdata = m_rdata; chk_bus = 1'b0;
    step();
    // core inputs may wander while stalled; the access must use the latched copy
    core_we = 1'($urandom_range(0, 1)); core_size = 3'($urandom_range(0, 7));
    core_addr = $urandom; core_wdata = $urandom;

    if (misal) begin
      if (!we) m_rdata = 32'h0;
      e_stall = 1'b0; e_merr = 1'b1; e_rdata = m_rdata;
      step();
    end else begin
      chk_bus = 1'b1; e_breq = 1'b1;
      e_baddr = addr & 32'hFFFF_FFFC; e_bwe = we; e_bstrb = strb; e_bwdata = ew; e_wmask = mask;
      for (int c = 0; c <= dr; c++) begin
        bus_req_ready = (c == dr);
        bus_rsp_valid = (c == dr) && (ds == 0);
        step();
      end
      chk_bus = 1'b0; e_breq = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
      tmo = 1'b0;
      if (ds != 0) begin
        for (int w = 1; w <= T; w++) begin
          bus_rsp_valid = (w == ds);
          step();
          if (w == ds) break;
          if (w == T) tmo = 1'b1;
        end
        bus_rsp_valid = 1'b0;
      end
      if (tmo) m_rdata = 32'h0;
      else if (!we) m_rdata = model_load(size, lo, rdata);
      e_stall = 1'b0; e_berr = tmo; e_rdata = m_rdata;
      step();
    end
    if (gap) begin
      set_idle();
      bus_rsp_valid = 1'($urandom_range(0, 1));
      step();
      bus_rsp_valid = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic        r_we_v;
    logic [2:0]  r_sz;
    int          r_dr, r_ds;

    rst = 1'b1; core_req = 1'b1; core_we = 1'b1; core_addr = 32'h123; core_wdata = 32'hFFFF_FFFF;
    core_size = 3'b010; bus_req_ready = 1'b1; bus_rsp_valid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    m_rdata = 32'h0;
    e_stall = 1'b0; e_breq = 1'b0; e_berr = 1'b0; e_merr = 1'b0; e_rdata = 32'h0;
    e_baddr = 32'h0; e_bwe = 1'b0; e_bstrb = 4'h0; e_bwdata = 32'h0; e_wmask = 32'hFFFF_FFFF;
    chk_bus = 1'b1; chk_en = 1'b1;
    step();
    step();
    rst = 1'b0;
    set_idle();
    step();

    do_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hCAFE_F00D, 0, 1, 1'b1);
    lit_check("lw_rdata", core_rdata, 32'hCAFE_F00D);

    do_access(1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b1);
    lit_check("sw_strb", 32'(obs_strb), 32'hF);
    lit_check("sw_addr", obs_addr, 32'h104);
    lit_check("sw_wdata", obs_wdata, 32'hDEAD_BEEF);
    lit_check("sw_stall_cycles", 32'(obs_stall), 32'd2);
    lit_check("sw_rdata_kept", core_rdata, 32'hCAFE_F00D);

    do_access(1'b1, 3'b000, 32'h203, 32'h0000_00A5, 32'h0, 1, 2, 1'b1);
    lit_check("sb_addr", obs_addr, 32'h200);
    lit_check("sb_strb", 32'(obs_strb), 32'h8);
    lit_check("sb_lane3", obs_wdata >> 24, 32'hA5);

    do_access(1'b0, 3'b000, 32'h202, 32'h0, 32'h12F0_3456, 0, 1, 1'b1);
    lit_check("lb_rdata", core_rdata, 32'hFFFF_FFF0);
    do_access(1'b0, 3'b100, 32'h202, 32'h0, 32'h12F0_3456, 2, 0, 1'b1);
    lit_check("lbu_rdata", core_rdata, 32'h0000_00F0);
    do_access(1'b0, 3'b001, 32'h202, 32'h0, 32'h12F0_3456, 0, 3, 1'b1);
    lit_check("lh_rdata", core_rdata, 32'h0000_12F0);

    // reset in WAIT_RSP, then a late response while idle
    core_req = 1'b1; core_we = 1'b0; core_size = 3'b010; core_addr = 32'h300;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'h7777_7777;
    e_stall = 1'b1; e_breq = 1'b0; e_berr = 1'b0; e_merr = 1'b0; e_rdata = m_rdata; chk_bus = 1'b0;
    step();
    e_breq = 1'b1; bus_req_ready = 1'b1;
    step();
    e_breq = 1'b0; bus_req_ready = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    m_rdata = 32'h0;
    e_stall = 1'b0; e_breq = 1'b0; e_berr = 1'b0; e_merr = 1'b0; e_rdata = 32'h0;
    e_baddr = 32'h0; e_bwe = 1'b0; e_bstrb = 4'h0; e_bwdata = 32'h0; e_wmask = 32'hFFFF_FFFF;
    chk_bus = 1'b1;
    step();
    rst = 1'b0;
    set_idle();
    bus_rsp_valid = 1'b1;
    step();
    bus_rsp_valid = 1'b0;
    step();
    lit_check("rst_rdata", core_rdata, 32'h0);

    do_access(1'b0, 3'b010, 32'h100, 32'h0, 32'h1122_3344, 0, 0, 1'b1);
    do_access(1'b0, 3'b010, 32'h400, 32'h0, 32'h55AA_55AA, 5, NEVER, 1'b1);
    lit_check("to_stall_cycles", 32'(obs_stall), 32'd15);
    lit_check("to_valid_cycles", 32'(obs_valid), 32'd6);
    lit_check("to_bus_err_pulses", 32'(obs_berr), 32'd1);
    lit_check("to_rdata", core_rdata, 32'h0);

`ifdef MISALIGN_CHECK_EN
    do_access(1'b0, 3'b010, 32'h100, 32'h0, 32'h1122_3344, 0, 0, 1'b1);
    do_access(1'b0, 3'b010, 32'h101, 32'h0, 32'hFFFF_FFFF, 0, 0, 1'b1);
    lit_check("mis_err_pulses", 32'(obs_merr), 32'd1);
    lit_check("mis_valid_cycles", 32'(obs_valid), 32'd0);
    lit_check("mis_rdata", core_rdata, 32'h0);
`else
    do_access(1'b0, 3'b001, 32'h203, 32'h0, 32'h12F0_3456, 0, 1, 1'b1);
    lit_check("lh_odd_rdata", core_rdata, 32'h0000_12F0);
    lit_check("mis_err_pulses", 32'(obs_merr), 32'd0);
`endif

    for (int n = 0; n < 300; n++) begin
      r_we_v = 1'($urandom_range(0, 1));
      r_sz   = 3'($urandom_range(0, 7));
      r_dr   = int'($urandom_range(0, 3));
      r_ds   = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 4));
      do_access(r_we_v, r_sz, $urandom, $urandom, $urandom, r_dr, r_ds, 1'($urandom_range(0, 1)));
    end

    set_idle();
    step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
